sram_arb: RTL

SRAM_ARB -- requirements
Module: sram_arb

---
 rtl/sram_arb.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sram_arb.sv
// sram_arb -- two-port arbiter in front of a single asynchronous SRAM.
//
// Port A (CPU) and port B (UART control path) each issue single byte
// accesses with a req/ack handshake. A grant latches the winner's address,
// write data and direction into registered SRAM pins, holds the read or
// write strobe for WAIT_CYC cycles, then pulses that port's ack for one
// cycle. Read data is captured on the last strobe cycle and held in the
// port's rdat register until that port's next read completes.
//
// Parameters:
//   WAIT_CYC   strobe width in cycles (1..15)
// Optional feature:
//   SRAM_ARB_RR_EN  when defined, simultaneous requests alternate
//                   (round-robin); otherwise port A has fixed priority.
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdat  port A request, direction, address, data
//   a_ack/a_rdat            port A completion pulse and read data
//   b_*                     port B, same meaning as port A
//   sram_addr/sram_dout     registered SRAM address / write data
//   sram_din                SRAM read data
//   sram_oe/sram_we         registered read / write strobes
module sram_arb #(
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [18:0] a_addr,
  input  logic [7:0]  a_wdat,
  output logic        a_ack,
  output logic [7:0]  a_rdat,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [18:0] b_addr,
  input  logic [7:0]  b_wdat,
  output logic        b_ack,
  output logic [7:0]  b_rdat,
  output logic [18:0] sram_addr,
  output logic [7:0]  sram_dout,
  input  logic [7:0]  sram_din,
  output logic        sram_oe,
  output logic        sram_we
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_sel_b, w_sel_b_nxt;
  logic        r_wr, w_wr_nxt;
  logic [18:0] r_addr, w_addr_nxt;
  logic [7:0]  r_dout, w_dout_nxt;
  logic        r_oe, w_oe_nxt;
  logic        r_we, w_we_nxt;
  logic        r_a_ack, w_a_ack_nxt;
  logic        r_b_ack, w_b_ack_nxt;
  logic [7:0]  r_a_rdat, w_a_rdat_nxt;
  logic [7:0]  r_b_rdat, w_b_rdat_nxt;

  logic        w_gnt_b;
  logic        w_gnt_we;
  logic [18:0] w_gnt_addr;
  logic [7:0]  w_gnt_wdat;

`ifdef SRAM_ARB_RR_EN
  // 1 = port B won the most recent grant
  logic r_last_b, w_last_b_nxt;
  assign w_gnt_b = b_req & (~a_req | ~r_last_b);
`else
  assign w_gnt_b = b_req & ~a_req;
`endif

  assign w_gnt_we   = w_gnt_b ? b_we   : a_we;
  assign w_gnt_addr = w_gnt_b ? b_addr : a_addr;
  assign w_gnt_wdat = w_gnt_b ? b_wdat : a_wdat;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sel_b_nxt  = r_sel_b;
    w_wr_nxt     = r_wr;
    w_addr_nxt   = r_addr;
    w_dout_nxt   = r_dout;
    w_oe_nxt     = 1'b0;
    w_we_nxt     = 1'b0;
    w_a_ack_nxt  = 1'b0;
    w_b_ack_nxt  = 1'b0;
    w_a_rdat_nxt = r_a_rdat;
    w_b_rdat_nxt = r_b_rdat;
`ifdef SRAM_ARB_RR_EN
    w_last_b_nxt = r_last_b;
`endif
    case (r_state)
      IDLE: begin
        if (a_req | b_req) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = LP_WAIT;
          w_sel_b_nxt = w_gnt_b;
          w_wr_nxt    = w_gnt_we;
          w_addr_nxt  = w_gnt_addr;
          w_dout_nxt  = w_gnt_wdat;
          w_oe_nxt    = ~w_gnt_we;
          w_we_nxt    = w_gnt_we;
`ifdef SRAM_ARB_RR_EN
          w_last_b_nxt = w_gnt_b;
`endif
        end
      end
      ACCESS: begin
        w_cnt_nxt = (r_cnt != '0) ? r_cnt - 4'd1 : '0;
        // r_cnt counts remaining strobe cycles including the current one
        if (r_cnt <= 4'd1) begin
          w_state_nxt = DONE;
          w_a_ack_nxt = ~r_sel_b;
          w_b_ack_nxt = r_sel_b;
          if (!r_wr) begin
            if (r_sel_b) w_b_rdat_nxt = sram_din;
            else         w_a_rdat_nxt = sram_din;
          end
        end else begin
          w_oe_nxt = ~r_wr;
          w_we_nxt = r_wr;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_sel_b  <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_dout   <= '0;
      r_oe     <= 1'b0;
      r_we     <= 1'b0;
      r_a_ack  <= 1'b0;
      r_b_ack  <= 1'b0;
      r_a_rdat <= '0;
      r_b_rdat <= '0;
`ifdef SRAM_ARB_RR_EN
      r_last_b <= 1'b1;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sel_b  <= w_sel_b_nxt;
      r_wr     <= w_wr_nxt;
      r_addr   <= w_addr_nxt;
      r_dout   <= w_dout_nxt;
      r_oe     <= w_oe_nxt;
      r_we     <= w_we_nxt;
      r_a_ack  <= w_a_ack_nxt;
      r_b_ack  <= w_b_ack_nxt;
      r_a_rdat <= w_a_rdat_nxt;
      r_b_rdat <= w_b_rdat_nxt;
`ifdef SRAM_ARB_RR_EN
      r_last_b <= w_last_b_nxt;
`endif
    end
  end

  assign sram_addr = r_addr;
  assign sram_dout = r_dout;
  assign sram_oe   = r_oe;
  assign sram_we   = r_we;
  assign a_ack     = r_a_ack;
  assign b_ack     = r_b_ack;
  assign a_rdat    = r_a_rdat;
  assign b_rdat    = r_b_rdat;

endmodule
